// File: rtl/exp6_unidade_mostra_sequencia.sv
// Shows the stored sequence on the LEDs: reads entries 0..limite from a synchronous-read
// memory and lights each one for T_ACESO cycles, followed by a T_APAGADO-cycle dark gap.
module exp6_unidade_mostra_sequencia #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned T_ACESO   = 4,
    parameter int unsigned T_APAGADO = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              abortar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [DATA_W-1:0] dado_mem,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              mostrando,
    output logic              fim_mostra,
    output logic [3:0]        db_estado
);

    localparam int unsigned TMax   = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
    localparam int unsigned TimerW = $clog2(TMax) + 1;

    localparam logic [TimerW-1:0] TAcesoLast   = TimerW'(T_ACESO - 1);
    localparam logic [TimerW-1:0] TApagadoLast = TimerW'(T_APAGADO - 1);

    typedef enum logic [2:0] {
        StInicial    = 3'd0,
        StPreparacao = 3'd1,
        StCarrega    = 3'd2,
        StAcende     = 3'd3,
        StApaga      = 3'd4,
        StProximo    = 3'd5,
        StFim        = 3'd6
    } estado_e;

    estado_e           state_q;
    logic [ADDR_W-1:0] endereco_q;
    logic [ADDR_W-1:0] limite_q;
    logic [TimerW-1:0] timer_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StInicial;
            endereco_q <= '0;
            limite_q   <= '0;
            timer_q    <= '0;
        end else if (abortar) begin
            state_q <= StInicial;
            timer_q <= '0;
        end else begin
            case (state_q)
                StInicial: begin
                    if (iniciar) begin
                        state_q <= StPreparacao;
                    end
                end
                StPreparacao: begin
                    endereco_q <= '0;
                    timer_q    <= '0;
                    limite_q   <= limite;
                    state_q    <= StCarrega;
                end
                StCarrega: begin
                    state_q <= StAcende;
                end
                StAcende: begin
                    if (timer_q == TAcesoLast) begin
                        timer_q <= '0;
                        state_q <= StApaga;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StApaga: begin
                    if (timer_q == TApagadoLast) begin
                        timer_q <= '0;
                        // Compare before incrementing so the last address never wraps.
                        state_q <= (endereco_q == limite_q) ? StFim : StProximo;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StProximo: begin
                    endereco_q <= endereco_q + 1'b1;
                    state_q    <= StCarrega;
                end
                StFim: begin
                    state_q <= StInicial;
                end
                default: begin
                    state_q <= StInicial;
                    timer_q <= '0;
                end
            endcase
        end
    end

    // Moore decode; leds follows the memory data directly since the read lands during acende.
    always_comb begin
        endereco   = endereco_q;
        leds       = '0;
        mostrando  = 1'b0;
        fim_mostra = 1'b0;
        db_estado  = 4'hF;
        case (state_q)
            StInicial: begin
                db_estado = 4'd0;
            end
            StPreparacao: begin
                mostrando = 1'b1;
                db_estado = 4'd1;
            end
            StCarrega: begin
                mostrando = 1'b1;
                db_estado = 4'd2;
            end
            StAcende: begin
                leds      = dado_mem;
                mostrando = 1'b1;
                db_estado = 4'd3;
            end
            StApaga: begin
                mostrando = 1'b1;
                db_estado = 4'd4;
            end
            StProximo: begin
                mostrando = 1'b1;
                db_estado = 4'd5;
            end
            StFim: begin
                fim_mostra = 1'b1;
                db_estado  = 4'd6;
            end
            default: begin
                db_estado = 4'hF;
            end
        endcase
    end

endmodule

// File: tb/tb_exp6_unidade_mostra_sequencia.sv
// Scoreboard bench: stimulus pushes expected lit cycles, fim spans and state traces;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_exp6_unidade_mostra_sequencia;

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          iniciar;
    logic          abortar;
    logic [AW-1:0] limite;
    logic [DW-1:0] dado_mem;
    logic [AW-1:0] endereco;
    logic [DW-1:0] leds;
    logic          mostrando;
    logic          fim_mostra;
    logic [3:0]    db_estado;

    logic [DW-1:0] mem [4];

    int n_checks = 0;
    int n_pass   = 0;

    int lit_q[$];
    int fim_q[$];
    int trace_q[$];

    int cyc      = 0;
    int prep_cyc = 0;
    logic [3:0] prev_db = 4'd0;

    exp6_unidade_mostra_sequencia #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .T_ACESO  (4),
        .T_APAGADO(2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .abortar   (abortar),
        .limite    (limite),
        .dado_mem  (dado_mem),
        .endereco  (endereco),
        .leds      (leds),
        .mostrando (mostrando),
        .fim_mostra(fim_mostra),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) dado_mem <= mem[endereco];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic unexpected(input string name, input int act);
        n_checks++;
        $display("FAIL %s: got %0d expected nothing", name, act);
    endtask

    // Monitor: compares every DUT event against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (db_estado != prev_db) begin
                if (db_estado == 4'd1) prep_cyc = cyc;
                if (trace_q.size() == 0) unexpected("db_trace", int'(db_estado));
                else check("db_trace", int'(db_estado), trace_q.pop_front());
                prev_db = db_estado;
            end
            if (leds != '0) begin
                if (lit_q.size() == 0) unexpected("lit", int'({endereco, leds}));
                else check("lit_addr_leds", int'({endereco, leds}), lit_q.pop_front());
            end
            if (fim_mostra) begin
                if (fim_q.size() == 0) unexpected("fim_pulse", cyc - prep_cyc);
                else check("fim_span", cyc - prep_cyc, fim_q.pop_front());
            end
        end
    end

    task automatic push_show(input int first, input int last);
        for (int a = first; a <= last; a++)
            for (int k = 0; k < 4; k++) lit_q.push_back(int'({a[AW-1:0], mem[a]}));
    endtask

    task automatic push_trace(input int n_entries, input bit with_fim);
        trace_q.push_back(1);
        for (int e = 0; e < n_entries; e++) begin
            trace_q.push_back(2);
            trace_q.push_back(3);
            trace_q.push_back(4);
            if (e != n_entries - 1) trace_q.push_back(5);
        end
        if (with_fim) begin
            trace_q.push_back(6);
            trace_q.push_back(0);
            fim_q.push_back(1 + n_entries * 7 + (n_entries - 1));
        end
    endtask

    // Returns at the negedge where db_estado enters v for the nth time.
    task automatic wait_db(input logic [3:0] v, input int nth);
        int   seen = 0;
        logic [3:0] prev = db_estado;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (db_estado == v && prev != v) seen++;
            prev = db_estado;
            if (seen == nth) return;
        end
        unexpected("wait_db_timeout", int'(v));
    endtask

    task automatic pulse_iniciar();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    initial begin
        mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8;
        reset = 1'b0; iniciar = 1'b0; abortar = 1'b0; limite = '0;
        #3;
        check("rst_db", int'(db_estado), 0);
        check("rst_leds", int'(leds), 0);
        check("rst_mostrando", int'(mostrando), 0);
        check("rst_fim", int'(fim_mostra), 0);
        check("rst_endereco", int'(endereco), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        check("idle_db", int'(db_estado), 0);

        // Three entries, 1-cycle iniciar
        limite = 2'd2;
        push_show(0, 2);
        push_trace(3, 1'b1);
        pulse_iniciar();
        check("prep_mostrando", int'(mostrando), 1);
        wait_db(4'd6, 1);
        repeat (3) @(negedge clock);

        // Single entry
        mem[0] = 4'd8;
        limite = 2'd0;
        push_show(0, 0);
        push_trace(1, 1'b1);
        pulse_iniciar();
        wait_db(4'd6, 1);
        repeat (3) @(negedge clock);
        mem[0] = 4'd1;

        // limite changes after preparacao are ignored
        limite = 2'd1;
        push_show(0, 1);
        push_trace(2, 1'b1);
        pulse_iniciar();
        wait_db(4'd3, 1);
        limite = 2'd3;
        wait_db(4'd6, 1);
        repeat (3) @(negedge clock);

        // Abort during second apaga, then a fresh start
        limite = 2'd2;
        push_show(0, 1);
        push_trace(2, 1'b0);
        trace_q.push_back(0);
        pulse_iniciar();
        wait_db(4'd4, 2);
        abortar = 1'b1;
        @(negedge clock);
        abortar = 1'b0;
        check("abort_db", int'(db_estado), 0);
        check("abort_leds", int'(leds), 0);
        check("abort_fim", int'(fim_mostra), 0);
        repeat (3) @(negedge clock);
        limite = 2'd0;
        push_show(0, 0);
        push_trace(1, 1'b1);
        pulse_iniciar();
        wait_db(4'd6, 1);
        repeat (3) @(negedge clock);

        // Async reset during the second acende
        limite = 2'd2;
        push_show(0, 0);
        lit_q.push_back(int'({2'd1, mem[1]}));
        trace_q.push_back(1); trace_q.push_back(2); trace_q.push_back(3);
        trace_q.push_back(4); trace_q.push_back(5); trace_q.push_back(2);
        trace_q.push_back(3); trace_q.push_back(0);
        pulse_iniciar();
        wait_db(4'd3, 2);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("midrst_leds", int'(leds), 0);
        check("midrst_endereco", int'(endereco), 0);
        check("midrst_mostrando", int'(mostrando), 0);
        check("midrst_db", int'(db_estado), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check("postrst_idle_db", int'(db_estado), 0);

        // Held iniciar over the full address range
        limite = 2'd3;
        push_show(0, 3);
        push_trace(4, 1'b1);
        trace_q.push_back(1);
        trace_q.push_back(0);
        iniciar = 1'b1;
        wait_db(4'd6, 1);
        wait_db(4'd1, 1);
        abortar = 1'b1;
        iniciar = 1'b0;
        @(negedge clock);
        abortar = 1'b0;
        repeat (4) @(negedge clock);

        check("lit_q_drained", lit_q.size(), 0);
        check("fim_q_drained", fim_q.size(), 0);
        check("trace_q_drained", trace_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/exp6_unidade_mostra_sequencia.md
Name: exp6_unidade_mostra_sequencia

Overview:
- Presents the stored jogo sequence to the player before the player's input phase: reads memory entries 0..limite in order and lights each entry on the LEDs with fixed on/off timing.
- Output direction of the player interface. The existing jogada-checking control unit consumes player input; this block drives the LEDs that the player watches.
- Owns an internal address counter and interval timer. Talks to a synchronous-read sequence memory (1-cycle read latency).
- Pulses fim_mostra when the presentation is complete so the top level can start the jogada phase.

Parameters:
- ADDR_W, 4, width of memory address and limite.
- DATA_W, 4, width of memory word and leds.
- T_ACESO, 4, cycles each entry is lit (>=1).
- T_APAGADO, 2, cycles dark gap after each entry (>=1).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- iniciar  in  1  start presentation; sampled only in state inicial.
- abortar  in  1  synchronous abort; from any state, next state is inicial.
- limite  in  ADDR_W  index of last entry to show (round number); captured in preparacao.
- dado_mem  in  DATA_W  memory read data; valid the cycle after endereco is presented.
- endereco  out  ADDR_W  memory read address (= internal address counter).
- leds  out  DATA_W  dado_mem while in acende, else 0.
- mostrando  out  1  1 in preparacao, carrega, acende, apaga, proximo.
- fim_mostra  out  1  1-cycle pulse in state fim.
- db_estado  out  4  debug state code.

Behaviour:
- reset=0 (async): state inicial; address counter, timer and limite register cleared. All outputs 0, db_estado=0.
- State codes / db_estado: inicial 0, preparacao 1, carrega 2, acende 3, apaga 4, proximo 5, fim 6. An illegal code shows F and goes to inicial next cycle.
- Moore outputs only. abortar has priority over every other transition, including iniciar in inicial.
- inicial: waits. iniciar=1 -> preparacao.
- preparacao, 1 cycle: address <= 0, timer <= 0, limite_reg <= limite -> carrega.
- carrega, 1 cycle: endereco stable; memory captures the address at this cycle's closing edge -> acende.
- acende: leds=dado_mem and endereco held constant. Timer increments each cycle. When timer==T_ACESO-1: timer <= 0 -> apaga. acende lasts exactly T_ACESO cycles.
- apaga: leds=0, timer increments. When timer==T_APAGADO-1: timer <= 0, then:
  - address==limite_reg -> fim;
  - otherwise -> proximo.
- proximo, 1 cycle: address <= address+1 -> carrega.
- fim, 1 cycle: fim_mostra=1, mostrando=0 -> inicial. The address counter retains its last value and clears in the next preparacao.
- Timer width: $clog2(max(T_ACESO,T_APAGADO))+1. Timer is held at 0 outside acende and apaga.
- limite changes after preparacao are ignored.
- limite=0: exactly one entry is shown.
- limite=2^ADDR_W-1: all entries are shown. The address never wraps because the equality check precedes the increment.
- iniciar outside inicial: ignored, including iniciar held high through fim. A held iniciar restarts the presentation on the cycle after returning to inicial.
- Reset or abortar mid-presentation: leds go to 0 immediately (reset) or at the next edge (abortar). No fim_mostra pulse is emitted.
- Cycle count, with N=limite+1:
  - preparacao to the first cycle of fim spans 1 + N*(1+T_ACESO+T_APAGADO) + (N-1) cycles.
  - iniciar to fim_mostra adds 1 more cycle.

Test Plan:
- Reset values: hold reset=0 mid-acende -> leds=0, endereco=0, mostrando=0, db_estado=0 asynchronously. After release, the block stays in inicial until iniciar.
- Three-entry show with defaults: memory {0:1,1:2,2:4}, limite=2, 1-cycle iniciar. Required response:
  - leds shows 1, 2, 4, each for exactly 4 cycles with 2-cycle dark gaps;
  - endereco steps 0,1,2;
  - fim_mostra pulses once, 24 cycles after preparacao entry;
  - db_estado traces 1,2,3,4,5,... ,6,0.
- Single entry: limite=0, mem[0]=8 -> leds=8 for 4 cycles, then 2 dark cycles, then fim_mostra with no proximo state visited.
- limite capture: limite=1 at start, changed to 3 during the first acende -> exactly 2 entries are shown.
- Abort: abortar=1 during the second apaga -> next cycle is inicial, fim_mostra stays 0, leds=0. A fresh iniciar restarts at endereco 0.
- Held iniciar and full range: ADDR_W=2, limite=3, iniciar held high -> entries 0..3 are shown with no wrap to 0 before fim. fim_mostra is followed by inicial then preparacao again; iniciar is ignored mid-show.
